// File: rtl/i2c_eeprom_responder_if.sv
// Two-wire bus seen by the EEPROM responder: raw SCL/SDA in, open-drain pull-down out.
`timescale 1ns/1ps

interface i2c_eeprom_responder_if;
    logic SCL_IN;
    logic SDA_IN;
    logic SDA_OE;

    modport master (output SCL_IN, output SDA_IN, input SDA_OE);
    modport slave  (input SCL_IN, input SDA_IN, output SDA_OE);
endinterface

// File: rtl/i2c_eeprom_responder.sv
// I2C target model of a small serial EEPROM: byte/page writes, random/sequential reads.
// SCL and SDA are oversampled on CLK; nothing here is clocked by SCL.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | bus free, waiting for START
// CTRL      | shifting in the control byte
// ACK_CTRL  | acknowledging our address; R/W decides the next state
// WADDR     | shifting in the word address
// ACK_WADDR | acknowledging the word address
// WDATA     | shifting in a data byte to commit at PTR
// ACK_WDATA | acknowledging a committed data byte
// RDATA     | driving array[PTR] out MSB first
// RACK      | sampling the master's ACK/NACK after a read byte
// WAIT      | not our transfer (or read ended); ignore SCL until START/STOP
`timescale 1ns/1ps

module i2c_eeprom_responder #(
    parameter logic [6:0] DEV_ADDR = 7'h50,
    parameter int         DEPTH    = 16,
    parameter int         AW       = 4
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    i2c_eeprom_responder_if.slave bus,
    output logic                 BUSY,
    output logic                 WR_STB,
    output logic [AW-1:0]        PTR,
    input  logic [AW-1:0]        DBG_ADDR,
    output logic [7:0]           DBG_DATA
);

    typedef enum logic [3:0] {
        IDLE, CTRL, ACK_CTRL, WADDR, ACK_WADDR, WDATA, ACK_WDATA, RDATA, RACK, WAIT
    } state_t;

    state_t     state;
    logic       scl_s1, scl_s2, scl_d;
    logic       sda_s1, sda_s2, sda_d;
    logic [2:0] bit_cnt;
    logic [7:0] shift;
    logic       byte_done;   // full byte shifted in last cycle; acted on one CLK later
    logic       phase;       // second half of an ACK slot, or master ACK seen in RACK
    logic       rw;
    logic       sda_oe;
    logic [7:0] mem [DEPTH];
    logic [7:0] rd_byte;

    logic scl_rise, scl_fall, start_c, stop_c;

    assign scl_rise = scl_s2 & ~scl_d;
    assign scl_fall = ~scl_s2 & scl_d;
    assign start_c  = scl_s2 & scl_d & sda_d & ~sda_s2;
    assign stop_c   = scl_s2 & scl_d & ~sda_d & sda_s2;

    assign rd_byte    = mem[PTR];
    assign DBG_DATA   = mem[DBG_ADDR];
    assign bus.SDA_OE = sda_oe;

    // Two-flop synchronizers plus one history stage; idle bus level is high.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            {scl_s1, scl_s2, scl_d} <= 3'b111;
            {sda_s1, sda_s2, sda_d} <= 3'b111;
        end else begin
            scl_s1 <= bus.SCL_IN;
            scl_s2 <= scl_s1;
            scl_d  <= scl_s2;
            sda_s1 <= bus.SDA_IN;
            sda_s2 <= sda_s1;
            sda_d  <= sda_s2;
        end
    end

    // Protocol FSM, pointer and array; START/STOP override everything else.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            byte_done <= 1'b0;
            phase     <= 1'b0;
            rw        <= 1'b0;
            sda_oe    <= 1'b0;
            BUSY      <= 1'b0;
            WR_STB    <= 1'b0;
            PTR       <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            WR_STB    <= 1'b0;
            byte_done <= 1'b0;
            if (start_c) begin
                state   <= CTRL;
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
                phase   <= 1'b0;
            end else if (stop_c) begin
                state  <= IDLE;
                sda_oe <= 1'b0;
                BUSY   <= 1'b0;
                phase  <= 1'b0;
            end else begin
                case (state)
                    CTRL, WADDR, WDATA: begin
                        if (scl_rise) begin
                            shift   <= {shift[6:0], sda_s2};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) byte_done <= 1'b1;
                        end
                        if (byte_done) begin
                            phase <= 1'b0;
                            if (state == CTRL) begin
                                if (shift[7:1] == DEV_ADDR) begin
                                    state <= ACK_CTRL;
                                    BUSY  <= 1'b1;
                                    rw    <= shift[0];
                                end else begin
                                    state <= WAIT;
                                    BUSY  <= 1'b0;
                                end
                            end else if (state == WADDR) begin
                                PTR   <= shift[AW-1:0];
                                state <= ACK_WADDR;
                            end else begin
                                mem[PTR] <= shift;
                                WR_STB   <= 1'b1;
                                PTR      <= PTR + AW'(1);
                                state    <= ACK_WDATA;
                            end
                        end
                    end
                    ACK_CTRL, ACK_WADDR, ACK_WDATA: begin
                        if (scl_fall) begin
                            if (!phase) begin
                                sda_oe <= 1'b1;
                                phase  <= 1'b1;
                            end else begin
                                phase <= 1'b0;
                                if (state == ACK_CTRL && rw) begin
                                    shift   <= {rd_byte[6:0], 1'b0};
                                    sda_oe  <= ~rd_byte[7];
                                    bit_cnt <= '0;
                                    state   <= RDATA;
                                end else begin
                                    sda_oe <= 1'b0;
                                    state  <= (state == ACK_CTRL) ? WADDR : WDATA;
                                end
                            end
                        end
                    end
                    RDATA: begin
                        if (scl_fall) begin
                            if (bit_cnt == 3'd7) begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= '0;
                                state   <= RACK;
                            end else begin
                                sda_oe  <= ~shift[7];
                                shift   <= {shift[6:0], 1'b0};
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                    end
                    RACK: begin
                        if (scl_rise) begin
                            PTR <= PTR + AW'(1);
                            if (sda_s2) state <= WAIT;
                            else        phase <= 1'b1;
                        end else if (scl_fall && phase) begin
                            // PTR was already advanced on the ACK rise
                            phase   <= 1'b0;
                            shift   <= {rd_byte[6:0], 1'b0};
                            sda_oe  <= ~rd_byte[7];
                            bit_cnt <= '0;
                            state   <= RDATA;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
